// File: rtl/conv_layer_ctrl.sv
// Sequences one convolution layer pass: weight load, feature-map stream,
// result capture into the output BRAM, then a done pulse or a timeout abort.
module conv_layer_ctrl #(
    parameter int KERNEL_SIZE = 3,
    parameter int FM_SIZE     = 8,
    parameter int PADDING     = 0,
    parameter int STRIDE      = 1,
    parameter int MAXPOOL     = 0,
    parameter int A_W         = 30,
    parameter int DW          = 16,
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT     = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_w_addr,
    input  logic [17:0]       i_w_rdata,
    output logic [ADDR_W-1:0] o_fm_addr,
    input  logic [A_W-1:0]    i_fm_rdata,
    output logic              o_weight_en,
    output logic [17:0]       o_weight_data,
    output logic              o_go,
    output logic [A_W-1:0]    o_fm_data,
    input  logic              i_conv_en,
    input  logic [DW-1:0]     i_conv_result,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DW-1:0]     o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [2:0]        o_state
);

    localparam int KK       = KERNEL_SIZE * KERNEL_SIZE;
    localparam int FM2      = FM_SIZE * FM_SIZE;
    localparam int OUT_SIZE = (FM_SIZE - KERNEL_SIZE + 2 * PADDING) / STRIDE + 1;
    localparam int N_OUT    = (MAXPOOL != 0) ? (OUT_SIZE / 2) * (OUT_SIZE / 2)
                                             : OUT_SIZE * OUT_SIZE;
    localparam int IW       = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] KK_A   = ADDR_W'(KK);
    localparam logic [ADDR_W-1:0] FM2_A  = ADDR_W'(FM2);
    localparam logic [ADDR_W-1:0] NOUT_A = ADDR_W'(N_OUT);
    localparam logic [IW-1:0]     TO_END = IW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_W    = 3'd1,
        STREAM_FM = 3'd2,
        DRAIN     = 3'd3,
        FINISH    = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] w_cnt, fm_cnt, res_cnt;
    logic [IW-1:0]     idle_cnt;
    logic              w_vld, fm_vld;
    logic              w_issue, fm_issue, w_last, fm_last;
    logic              capture, res_full, res_take, timeout_hit, accept;

    // Weight and FM strobes are valid-only: conv_blk has no ready, so each
    // strobe carries one word that must be consumed in the cycle it is high.
    assign w_issue     = (state == LOAD_W) && (w_cnt < KK_A);
    assign fm_issue    = (state == STREAM_FM) && (fm_cnt < FM2_A);
    assign w_last      = (state == LOAD_W) && w_vld && (w_cnt == KK_A);
    assign fm_last     = (state == STREAM_FM) && fm_vld && (fm_cnt == FM2_A);
    assign capture     = (state == LOAD_W) || (state == STREAM_FM) || (state == DRAIN);
    assign res_full    = (res_cnt == NOUT_A);
    assign res_take    = capture && i_conv_en && !res_full;
    assign timeout_hit = (state == DRAIN) && !i_conv_en && (idle_cnt == TO_END);
    assign accept      = (state == IDLE) && i_start;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (i_start) state_nx = LOAD_W;
            LOAD_W:    if (w_last) state_nx = STREAM_FM;
            STREAM_FM: if (fm_last) state_nx = DRAIN;
            DRAIN:     if (res_full || timeout_hit) state_nx = FINISH;
            FINISH:    state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            w_cnt     <= '0;
            fm_cnt    <= '0;
            res_cnt   <= '0;
            idle_cnt  <= '0;
            w_vld     <= 1'b0;
            fm_vld    <= 1'b0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_err     <= 1'b0;
        end else begin
            state   <= state_nx;
            w_vld   <= w_issue;
            fm_vld  <= fm_issue;
            o_wr_en <= res_take;
            if (res_take) begin
                o_wr_addr <= res_cnt;
                o_wr_data <= i_conv_result;
            end
            if (accept) begin
                w_cnt   <= '0;
                fm_cnt  <= '0;
                res_cnt <= '0;
                o_err   <= 1'b0;
            end else begin
                if (w_issue)  w_cnt   <= w_cnt + ADDR_W'(1);
                if (fm_issue) fm_cnt  <= fm_cnt + ADDR_W'(1);
                if (res_take) res_cnt <= res_cnt + ADDR_W'(1);
                // A final result landing on the timeout cycle wins over the abort.
                if (timeout_hit && !res_full) o_err <= 1'b1;
            end
            if ((state != DRAIN) || i_conv_en) idle_cnt <= '0;
            else                               idle_cnt <= idle_cnt + IW'(1);
        end
    end

    assign o_w_addr      = w_cnt;
    assign o_fm_addr     = fm_cnt;
    assign o_weight_en   = w_vld;
    assign o_weight_data = w_vld ? i_w_rdata : '0;
    assign o_go          = fm_vld;
    assign o_fm_data     = fm_vld ? i_fm_rdata : '0;
    assign o_busy        = (state != IDLE);
    assign o_done        = (state == FINISH);
    assign o_state       = state;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Bench for conv_layer_ctrl: two instances (plain and maxpool) share BRAM
// contents and a random conv_blk result source; results are scoreboarded.
module tb_conv_layer_ctrl;
  localparam int AW  = 12;
  localparam int A_W = 30;
  localparam int DW  = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_main, rst_drv;
  wire  rst = rst_main | rst_drv;

  logic sel;
  logic start_main, start_mid;
  wire  start0 = !sel & (start_main | start_mid);
  wire  start1 = sel & (start_main | start_mid);
  logic          conv_en;
  logic [DW-1:0] conv_res;

  logic [17:0]  wmem [16];
  logic [A_W-1:0] fmem [128];
  logic [17:0]  w_rdata0, w_rdata1;
  logic [A_W-1:0] fm_rdata0, fm_rdata1;

  logic [AW-1:0] w_addr0, fm_addr0, wr_addr0, w_addr1, fm_addr1, wr_addr1;
  logic          weight_en0, go0, wr_en0, busy0, done0, err0;
  logic          weight_en1, go1, wr_en1, busy1, done1, err1;
  logic [17:0]   weight_data0, weight_data1;
  logic [A_W-1:0] fm_data0, fm_data1;
  logic [DW-1:0] wr_data0, wr_data1;
  logic [2:0]    state0, state1;

  conv_layer_ctrl #(.MAXPOOL(0), .TIMEOUT(16)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0),
    .o_w_addr(w_addr0), .i_w_rdata(w_rdata0),
    .o_fm_addr(fm_addr0), .i_fm_rdata(fm_rdata0),
    .o_weight_en(weight_en0), .o_weight_data(weight_data0),
    .o_go(go0), .o_fm_data(fm_data0),
    .i_conv_en(conv_en), .i_conv_result(conv_res),
    .o_wr_en(wr_en0), .o_wr_addr(wr_addr0), .o_wr_data(wr_data0),
    .o_busy(busy0), .o_done(done0), .o_err(err0), .o_state(state0)
  );

  conv_layer_ctrl #(.MAXPOOL(1), .TIMEOUT(16)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1),
    .o_w_addr(w_addr1), .i_w_rdata(w_rdata1),
    .o_fm_addr(fm_addr1), .i_fm_rdata(fm_rdata1),
    .o_weight_en(weight_en1), .o_weight_data(weight_data1),
    .o_go(go1), .o_fm_data(fm_data1),
    .i_conv_en(conv_en), .i_conv_result(conv_res),
    .o_wr_en(wr_en1), .o_wr_addr(wr_addr1), .o_wr_data(wr_data1),
    .o_busy(busy1), .o_done(done1), .o_err(err1), .o_state(state1)
  );

  // BRAM models: one cycle read latency
  always @(posedge clk) begin
    w_rdata0  <= wmem[w_addr0[3:0]];
    w_rdata1  <= wmem[w_addr1[3:0]];
    fm_rdata0 <= fmem[fm_addr0[6:0]];
    fm_rdata1 <= fmem[fm_addr1[6:0]];
  end

  wire            s_weight_en   = sel ? weight_en1 : weight_en0;
  wire [17:0]     s_weight_data = sel ? weight_data1 : weight_data0;
  wire            s_go          = sel ? go1 : go0;
  wire [A_W-1:0]  s_fm_data     = sel ? fm_data1 : fm_data0;
  wire            s_wr_en       = sel ? wr_en1 : wr_en0;
  wire [AW-1:0]   s_wr_addr     = sel ? wr_addr1 : wr_addr0;
  wire [DW-1:0]   s_wr_data     = sel ? wr_data1 : wr_data0;
  wire            s_busy        = sel ? busy1 : busy0;
  wire            s_done        = sel ? done1 : done0;
  wire            s_err         = sel ? err1 : err0;
  wire            o_wr_other    = sel ? wr_en0 : wr_en1;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int w_idx, f_idx, go_runs, wr_cnt, done_cnt, done_cyc, last_wr_cyc, other_wr;
  int conv_left = 0;
  int conv_after = 0;
  bit go_prev, mid_req, rst_req, rst_chk, rst_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor (negedge sampling) followed by conv_blk result driver
  initial begin
    logic [DW-1:0] e;
    conv_en = 1'b0; conv_res = '0; rst_drv = 1'b0; start_mid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (s_weight_en) begin
        chk("weight_data", s_weight_data, wmem[w_idx % 16]);
        chk("weight_go_overlap", s_go, 1'b0);
        w_idx++;
      end
      if (s_go) begin
        chk("fm_data", s_fm_data, fmem[f_idx % 128]);
        if (!go_prev) go_runs++;
        f_idx++;
      end
      go_prev = s_go;
      if (s_wr_en) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("wr_addr", s_wr_addr, wr_cnt);
        chk("wr_data", s_wr_data, e);
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (o_wr_other) other_wr++;
      if (s_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rst_chk) begin
        chk("rst_wr_en", wr_en0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_state", state0, 3'd0);
        rst_chk = 1'b0;
      end
      rst_drv = 1'b0; start_mid = 1'b0; conv_en = 1'b0;
      if (rst_req && s_busy && f_idx >= 64 && wr_cnt >= 5) begin
        rst_drv = 1'b1; conv_en = 1'b1; conv_res = DW'($urandom);
        rst_req = 1'b0; rst_chk = 1'b1; rst_seen = 1'b1;
      end else begin
        if (mid_req && f_idx == 30) begin
          start_mid = 1'b1;
          mid_req = 1'b0;
        end
        if (conv_left > 0 && s_busy && f_idx >= conv_after && $urandom_range(0, 3) != 0) begin
          conv_en = 1'b1;
          conv_res = DW'($urandom_range(0, 65535));
          exp_q.push_back(conv_res);
          conv_left--;
        end
      end
    end
  end

  // driver tasks
  task automatic start_pass(input bit s, input int lim, input int after, input bit mid);
    sel = s; exp_q.delete();
    w_idx = 0; f_idx = 0; go_runs = 0; go_prev = 1'b0; wr_cnt = 0;
    done_cnt = 0; other_wr = 0; conv_left = lim; conv_after = after; mid_req = mid;
    start_main = 1'b1;
    @(posedge clk); #1;
    start_main = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (s_done) break;
    end
    chk("done_seen", s_done, 1'b1);
    chk("busy_at_done", s_busy, 1'b1);
  endtask

  task automatic end_pass(input int exp_wr, input bit exp_err);
    @(posedge clk); #1;
    chk("done_one_cycle", s_done, 1'b0);
    chk("busy_after", s_busy, 1'b0);
    chk("err", s_err, exp_err);
    chk("weight_count", w_idx, 9);
    chk("fm_count", f_idx, 64);
    chk("go_runs", go_runs, 1);
    chk("write_count", wr_cnt, exp_wr);
    chk("done_count", done_cnt, 1);
    chk("idle_dut_writes", other_wr, 0);
    if (exp_err) chk("timeout_gap", done_cyc - last_wr_cyc, 16);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) wmem[i] = 18'($urandom);
    for (int i = 0; i < 128; i++) fmem[i] = A_W'($urandom);
    rst_main = 1'b1; start_main = 1'b0; sel = 1'b0;
    mid_req = 1'b0; rst_req = 1'b0; rst_chk = 1'b0; rst_seen = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_busy0", busy0, 1'b0);
    chk("reset_done0", done0, 1'b0);
    chk("reset_err0", err0, 1'b0);
    chk("reset_wr_en0", wr_en0, 1'b0);
    chk("reset_w_addr0", w_addr0, 0);
    chk("reset_fm_addr0", fm_addr0, 0);
    chk("reset_go0", go0, 1'b0);
    chk("reset_weight_en0", weight_en0, 1'b0);
    chk("reset_state0", state0, 3'd0);
    chk("reset_busy1", busy1, 1'b0);
    rst_main = 1'b0;
    @(posedge clk); #1;

    // full pass, 36 results plus surplus that must be dropped
    start_pass(1'b0, 40, 20, 1'b0); wait_done(); end_pass(36, 1'b0);
    // maxpool instance: 9 results, a 10th is ignored
    start_pass(1'b1, 10, 0, 1'b0); wait_done(); end_pass(9, 1'b0);
    // results stop at 20 -> timeout
    start_pass(1'b0, 20, 64, 1'b0); wait_done(); end_pass(20, 1'b1);
    // back-to-back: started the cycle after done, err must clear
    start_pass(1'b0, 40, 20, 1'b0); wait_done(); end_pass(36, 1'b0);
    // start pulse mid stream is ignored
    start_pass(1'b0, 40, 10, 1'b1); wait_done(); end_pass(36, 1'b0);
    // reset in DRAIN with a result arriving
    start_pass(1'b0, 36, 64, 1'b0);
    rst_req = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (rst_seen) break;
    end
    chk("rst_in_drain_seen", rst_seen, 1'b1);
    rst_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    start_pass(1'b0, 40, 20, 1'b0); wait_done(); end_pass(36, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_layer_ctrl.md
Name: conv_layer_ctrl

Overview:
Sequencer for one convolution layer pass through conv_blk. Reads kernel weights from a weight BRAM and loads them into conv_blk, then streams the feature map from an FM BRAM. It collects every result conv_blk emits and writes it to an output BRAM. It flags completion, or flags a timeout if results stop arriving. It sits between the BRAM subsystem and a single conv_blk instance.

Parameters:
KERNEL_SIZE, 3, kernel side; the block loads KERNEL_SIZE*KERNEL_SIZE weights.
FM_SIZE, 8, feature map side; the block streams FM_SIZE*FM_SIZE words.
PADDING, 0, passed through only to compute OUT_SIZE.
STRIDE, 1, passed through only to compute OUT_SIZE.
MAXPOOL, 0, 1 = conv_blk is built with maxpool; changes the expected result count.
A_W, 30, FM data width (matches A_DSP_WIDTH).
DW, 16, result width (matches DW).
ADDR_W, 12, width of every BRAM address.
TIMEOUT, 1024, number of idle DRAIN cycles before the block aborts.

Derived values:
OUT_SIZE = (FM_SIZE-KERNEL_SIZE+2*PADDING)/STRIDE+1.
N_OUT = MAXPOOL ? (OUT_SIZE/2)^2 : OUT_SIZE^2.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
i_start  in  1  single-cycle pulse that starts a layer pass
o_w_addr  out  ADDR_W  weight BRAM read address
i_w_rdata  in  18  weight BRAM data; valid 1 cycle after its address
o_fm_addr  out  ADDR_W  FM BRAM read address
i_fm_rdata  in  A_W  FM BRAM data; valid 1 cycle after its address
o_weight_en  out  1  weight valid strobe to conv_blk
o_weight_data  out  18  weight word to conv_blk
o_go  out  1  FM stream valid to conv_blk
o_fm_data  out  A_W  FM word to conv_blk
i_conv_en  in  1  conv_blk result valid
i_conv_result  in  DW  conv_blk result
o_wr_en  out  1  output BRAM write enable
o_wr_addr  out  ADDR_W  output BRAM write address
o_wr_data  out  DW  output BRAM write data
o_busy  out  1  high from IDLE exit until return to IDLE
o_done  out  1  one-cycle completion pulse
o_err  out  1  sticky timeout flag; cleared by the next accepted i_start

Behaviour:
- Reset: state IDLE. Every output and every internal counter is 0. Reset mid-pass aborts immediately; no further BRAM writes occur.
- FSM states: IDLE, LOAD_W, STREAM_FM, DRAIN, FINISH.
- IDLE:
  - i_start goes to LOAD_W. It clears o_err, the address counters and the result counter.
  - i_start in any other state is ignored.
- LOAD_W:
  - o_w_addr runs 0..K*K-1, one address per cycle.
  - A 1-cycle delayed valid drives o_weight_en=1 with o_weight_data=i_w_rdata, for exactly K*K consecutive cycles.
  - The cycle after the last weight strobe: go to STREAM_FM.
  - o_weight_en and o_go are never high in the same cycle.
- STREAM_FM:
  - o_fm_addr runs 0..FM^2-1.
  - o_go=1 and o_fm_data=i_fm_rdata for exactly FM^2 consecutive cycles, data aligned with the 1-cycle BRAM latency.
  - Then o_go drops to 0 and the FSM goes to DRAIN.
- Result capture (active in LOAD_W, STREAM_FM and DRAIN):
  - Each cycle with i_conv_en=1 produces, on the next cycle, o_wr_en=1, o_wr_addr=result count and o_wr_data=i_conv_result. The result count then increments.
  - Results arriving during STREAM_FM are captured normally.
- DRAIN:
  - The idle counter resets on every i_conv_en and otherwise increments.
  - When the result count reaches N_OUT (after its final write is issued), go to FINISH.
  - When the idle counter reaches TIMEOUT, set o_err=1 and go to FINISH.
- FINISH: o_done=1 for one cycle, then IDLE; o_busy falls in the same cycle as the return to IDLE.
- i_conv_en after N_OUT results, or while IDLE: ignored, no write.
- Address counters are never compared against 2^ADDR_W. Sizing ADDR_W is the integrator's responsibility.

Test Plan:
- K=3, FM=8, MAXPOOL=0, model conv_blk echoing 36 results -> exactly 9 o_weight_en strobes carrying BRAM words 0..8, then exactly 64 contiguous o_go cycles carrying FM words 0..63, 36 writes to addresses 0..35, one o_done pulse, o_err=0.
- MAXPOOL=1, same sizes -> pass completes after 9 writes (addresses 0..8); any 10th i_conv_en produces no write.
- Model stops after 20 results, TIMEOUT=16 -> o_err=1, o_done pulses 16 cycles after the last result, o_busy falls.
- i_start pulsed again mid STREAM_FM -> no restart; addresses continue monotonically.
- i_rst asserted in DRAIN with i_conv_en active -> next cycle o_wr_en=0, o_busy=0, state IDLE; a new i_start runs a clean pass from address 0.
- Back-to-back passes, second started 1 cycle after o_done -> o_err cleared and write addresses restart at 0.
